if_stage: RTL

Instruction fetch stage plus IF/ID pipeline register. It owns the PC and issues word fetches to instruction memory over a req/gnt/rvalid handshake, allowing one outstanding request. It buffers one response when the ID stage is stalled, and presents instruction/PC/valid to id_stage (instruction_i, pc_address_i, if_valid_i). Redirects from EX (branch/jal/jalr) and stall/flush from the hazard unit are handled here.

---
 rtl/rv32_pkg.sv | 23 ++
 rtl/if_stage.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32_pkg
// Brief    : Shared constants and fetch FSM encoding for the RV32 pipeline.
// Revision : 1.0
// ============================================================================
package rv32_pkg;

    localparam logic [31:0] c_nop_instr = 32'h0000_0013;
    localparam logic [31:0] c_reset_pc  = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] i_addr);
        return {i_addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Brief    : Instruction fetch (one outstanding req/gnt/rvalid) + IF/ID register.
// Revision : 1.0
// ============================================================================
module if_stage
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = c_reset_pc,
    parameter logic [31:0] NOP_INSTR = c_nop_instr
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_address_o,
    output logic        if_valid_o
);

    fetch_state_e r_state, w_state_d;
    logic [31:0]  r_pc, w_pc_d;
    logic [31:0]  r_fetch_pc, w_fetch_pc_d;
    logic         r_drop, w_drop_d;
    logic [31:0]  r_buf_instr, w_buf_instr_d;
    logic [31:0]  r_buf_pc, w_buf_pc_d;
    logic [31:0]  r_instr, w_instr_d;
    logic [31:0]  r_ifpc, w_ifpc_d;
    logic         r_valid, w_valid_d;
    logic         w_deliver;
    logic [31:0]  w_dlv_instr;
    logic [31:0]  w_dlv_pc;

    assign imem_req_o    = (r_state == S_REQ) && !redirect_i;
    assign imem_addr_o   = r_pc;
    assign instruction_o = r_instr;
    assign pc_address_o  = r_ifpc;
    assign if_valid_o    = r_valid;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_fetch_pc  <= 32'h0;
            r_drop      <= 1'b0;
            r_buf_instr <= NOP_INSTR;
            r_buf_pc    <= 32'h0;
            r_instr     <= NOP_INSTR;
            r_ifpc      <= 32'h0;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_pc        <= w_pc_d;
            r_fetch_pc  <= w_fetch_pc_d;
            r_drop      <= w_drop_d;
            r_buf_instr <= w_buf_instr_d;
            r_buf_pc    <= w_buf_pc_d;
            r_instr     <= w_instr_d;
            r_ifpc      <= w_ifpc_d;
            r_valid     <= w_valid_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_pc_d        = r_pc;
        w_fetch_pc_d  = r_fetch_pc;
        w_drop_d      = r_drop;
        w_buf_instr_d = r_buf_instr;
        w_buf_pc_d    = r_buf_pc;
        w_deliver     = 1'b0;
        w_dlv_instr   = r_buf_instr;
        w_dlv_pc      = r_buf_pc;

        if (redirect_i) begin
            w_pc_d        = word_align(redirect_pc_i);
            w_buf_instr_d = NOP_INSTR;
            w_buf_pc_d    = 32'h0;
            w_drop_d      = 1'b0;
            case (r_state)
                // A response still in flight belongs to the old path: remember to drop it.
                S_WAIT: begin
                    if (imem_rvalid_i) w_state_d = S_REQ;
                    else               w_drop_d  = 1'b1;
                end
                S_HOLD:  w_state_d = S_REQ;
                default: w_state_d = S_REQ;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (imem_gnt_i) begin
                        w_fetch_pc_d = r_pc;
                        w_pc_d       = r_pc + 32'd4;
                        w_state_d    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        if (r_drop) begin
                            w_drop_d  = 1'b0;
                            w_state_d = S_REQ;
                        end else if (!stall_i) begin
                            w_deliver   = 1'b1;
                            w_dlv_instr = imem_rdata_i;
                            w_dlv_pc    = r_fetch_pc;
                            w_state_d   = S_REQ;
                        end else begin
                            w_buf_instr_d = imem_rdata_i;
                            w_buf_pc_d    = r_fetch_pc;
                            w_state_d     = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        w_deliver = 1'b1;
                        w_state_d = S_REQ;
                    end
                end
                default: w_state_d = S_REQ;
            endcase
        end
    end

    // A bubble keeps the last PC; only instruction and valid are cleared.
    always_comb begin
        w_instr_d = r_instr;
        w_ifpc_d  = r_ifpc;
        w_valid_d = r_valid;
        if (redirect_i || flush_i) begin
            w_instr_d = NOP_INSTR;
            w_valid_d = 1'b0;
        end else if (!stall_i) begin
            if (w_deliver) begin
                w_instr_d = w_dlv_instr;
                w_ifpc_d  = w_dlv_pc;
                w_valid_d = 1'b1;
            end else begin
                w_instr_d = NOP_INSTR;
                w_valid_d = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
